id_ex_pipe_reg: RTL and testbench

//  Decode->execute pipeline register. Captures decoded control, operands and register IDs each cycle.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_field_reg.sv | 22 ++
 rtl/id_ex_pipe_reg.sv | 118 +++++++++++
 tb/tb_id_ex_pipe_reg.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared decode/execute pipeline types: control bundle, its NOP encoding and default widths.
package pipe_pkg;

    localparam int DATA_W  = 16;
    localparam int PC_W    = 32;
    localparam int REG_W   = 3;
    localparam int ALUOP_W = 4;

    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               push;
        logic               pop;
        logic [ALUOP_W-1:0] alu_op;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: async reset, clear beats hold, hold beats load.
module pipe_field_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (!hold)
            q <= d;
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Decode->execute pipeline register with flush, hold and load-use bubble insertion.
// Optional bubble counter enabled by defining ID_EX_STATS_EN.
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = pipe_pkg::DATA_W,
    parameter int PC_W    = pipe_pkg::PC_W,
    parameter int REG_W   = pipe_pkg::REG_W,
    parameter int ALUOP_W = pipe_pkg::ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               hold,
    input  logic               bubble_sel,
    input  logic               in_valid,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [REG_W-1:0]   in_rs,
    input  logic [REG_W-1:0]   in_rd,
    input  logic [REG_W-1:0]   in_rdst,
    input  logic [DATA_W-1:0]  in_op_a,
    input  logic [DATA_W-1:0]  in_op_b,
    input  logic [DATA_W-1:0]  in_imm,
    input  logic [ALUOP_W-1:0] in_alu_op,
    input  logic               in_reg_write,
    input  logic               in_mem_read,
    input  logic               in_mem_write,
    input  logic               in_push,
    input  logic               in_pop,
    output logic               out_valid,
    output logic [PC_W-1:0]    out_pc,
    output logic [REG_W-1:0]   out_rs,
    output logic [REG_W-1:0]   out_rd,
    output logic [REG_W-1:0]   out_rdst,
    output logic [DATA_W-1:0]  out_op_a,
    output logic [DATA_W-1:0]  out_op_b,
    output logic [DATA_W-1:0]  out_imm,
    output logic [ALUOP_W-1:0] out_alu_op,
    output logic               out_reg_write,
    output logic               out_mem_read,
    output logic               out_mem_write,
    output logic               out_push,
    output logic               out_pop,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam int CTRL_W = $bits(id_ex_ctrl_t) + REG_W;
    localparam int DATA_FW = PC_W + 2*REG_W + 3*DATA_W;

    id_ex_ctrl_t ctrl_d, ctrl_q;
    logic        bubble_win;
    logic        ctrl_clr;

    // Hold outranks a bubble; flush outranks both.
    assign bubble_win = bubble_sel && !hold && !flush;
    assign ctrl_clr   = flush || (bubble_sel && !hold);

    always_comb begin
        ctrl_d           = CTRL_NOP;
        if (in_valid) begin
            ctrl_d.reg_write = in_reg_write;
            ctrl_d.mem_read  = in_mem_read;
            ctrl_d.mem_write = in_mem_write;
            ctrl_d.push      = in_push;
            ctrl_d.pop       = in_pop;
            ctrl_d.alu_op    = in_alu_op;
        end
    end

    // rdst rides with control so a bubble zeroes the hazard-unit feedback.
    pipe_field_reg #(.W(CTRL_W)) u_ctrl_reg (
        .clk  (clk),
        .rst  (rst),
        .hold (hold),
        .clr  (ctrl_clr),
        .d    ({ctrl_d, in_rdst}),
        .q    ({ctrl_q, out_rdst})
    );

    // Data/PC still load during a bubble for debug visibility.
    pipe_field_reg #(.W(DATA_FW)) u_data_reg (
        .clk  (clk),
        .rst  (rst),
        .hold (hold),
        .clr  (flush),
        .d    ({in_pc, in_rs, in_rd, in_op_a, in_op_b, in_imm}),
        .q    ({out_pc, out_rs, out_rd, out_op_a, out_op_b, out_imm})
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_valid <= 1'b0;
        else if (flush)
            out_valid <= 1'b0;
        else if (!hold)
            out_valid <= in_valid && !bubble_sel;
    end

    assign out_reg_write = ctrl_q.reg_write;
    assign out_mem_read  = ctrl_q.mem_read;
    assign out_mem_write = ctrl_q.mem_write;
    assign out_push      = ctrl_q.push;
    assign out_pop       = ctrl_q.pop;
    assign out_alu_op    = ctrl_q.alu_op;

`ifdef ID_EX_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bubble_cnt <= '0;
        else if (bubble_win && (bubble_cnt != '1))
            bubble_cnt <= bubble_cnt + 1'b1;
    end
`else
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: driver queues expected state per edge, monitor compares.
// Counter expectations follow ID_EX_STATS_EN when the bench is built with it.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [2:0]  rs;
        logic [2:0]  rd;
        logic [2:0]  rdst;
        logic [15:0] op_a;
        logic [15:0] op_b;
        logic [15:0] imm;
        logic [3:0]  alu_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        push;
        logic        pop;
    } fields_t;

    typedef struct {
        fields_t    f;
        logic [1:0] cnt;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0, hold = 1'b0, bubble_sel = 1'b0;
    fields_t din = '0;
    fields_t act;
    logic [1:0] bubble_cnt;

    exp_t    q[$];
    fields_t mf = '0;
    logic [1:0] mcnt = '0;
    logic async_chk = 1'b0;
    logic done = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .hold(hold), .bubble_sel(bubble_sel),
        .in_valid(din.valid), .in_pc(din.pc), .in_rs(din.rs), .in_rd(din.rd),
        .in_rdst(din.rdst), .in_op_a(din.op_a), .in_op_b(din.op_b), .in_imm(din.imm),
        .in_alu_op(din.alu_op), .in_reg_write(din.reg_write), .in_mem_read(din.mem_read),
        .in_mem_write(din.mem_write), .in_push(din.push), .in_pop(din.pop),
        .out_valid(act.valid), .out_pc(act.pc), .out_rs(act.rs), .out_rd(act.rd),
        .out_rdst(act.rdst), .out_op_a(act.op_a), .out_op_b(act.op_b), .out_imm(act.imm),
        .out_alu_op(act.alu_op), .out_reg_write(act.reg_write), .out_mem_read(act.mem_read),
        .out_mem_write(act.mem_write), .out_push(act.push), .out_pop(act.pop),
        .bubble_cnt(bubble_cnt)
    );

    // c = {reg_write, mem_read, mem_write, push, pop}; other fields derived from pc.
    function automatic fields_t mk(input logic v, input logic [31:0] pc, input logic [2:0] rdst,
                                   input logic [3:0] alu, input logic [4:0] c);
        fields_t r;
        r.valid  = v;
        r.pc     = pc;
        r.rs     = pc[4:2];
        r.rd     = pc[5:3];
        r.rdst   = rdst;
        r.op_a   = pc[15:0] ^ 16'h1234;
        r.op_b   = ~pc[15:0];
        r.imm    = pc[15:0] + 16'h0100;
        r.alu_op = alu;
        {r.reg_write, r.mem_read, r.mem_write, r.push, r.pop} = c;
        return r;
    endfunction

    function automatic fields_t kill_ctrl(input fields_t x);
        fields_t r = x;
        r.valid = 1'b0;
        r.alu_op = '0;
        {r.reg_write, r.mem_read, r.mem_write, r.push, r.pop} = '0;
        return r;
    endfunction

    task automatic push_exp(input string nm);
        exp_t e;
        e.f = mf;
        e.cnt = mcnt;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic drive(input fields_t v, input logic fl, input logic ho, input logic bu,
                         input string nm);
        @(negedge clk);
        din = v; flush = fl; hold = ho; bubble_sel = bu;
        if (fl) begin
            mf = '0;
        end else if (ho) begin
            mf = mf;
        end else if (bu) begin
            mf = kill_ctrl(v);
            mf.rdst = '0;
`ifdef ID_EX_STATS_EN
            if (mcnt != 2'b11) mcnt = mcnt + 2'd1;
`endif
        end else begin
            mf = v.valid ? v : kill_ctrl(v);
        end
        push_exp(nm);
    endtask

    // Assert rst mid-cycle; outputs must clear before the next edge.
    task automatic async_reset(input string nm);
        @(negedge clk);
        #1;
        rst = 1'b1;
        din = '0; flush = 1'b0; hold = 1'b0; bubble_sel = 1'b0;
        mf = '0;
        mcnt = '0;
        push_exp(nm);
        async_chk = 1'b1;
        #2 async_chk = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: one expectation per active edge (or async-reset probe), sampled just after.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk or posedge async_chk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (act !== e.f || bubble_cnt !== e.cnt) begin
                    n_bad++;
                    $display("FAIL %s: got fields=%h cnt=%0d, expected fields=%h cnt=%0d",
                             e.name, act, bubble_cnt, e.f, e.cnt);
                end
            end
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        // Reset state observed while rst is held.
        #3;
        push_exp("reset_state");
        async_chk = 1'b1;
        #2 async_chk = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;

        drive(mk(1, 32'h40, 3'd3, 4'd2, 5'b11000), 0, 0, 0, "load_pre_rst");
        async_reset("async_rst");

        drive(mk(1, 32'h40, 3'd3, 4'd2, 5'b01000), 0, 0, 0, "load");
        drive(mk(1, 32'h44, 3'd5, 4'd3, 5'b10000), 0, 0, 1, "bubble");
        drive(mk(0, 32'h48, 3'd1, 4'd5, 5'b10101), 0, 0, 0, "invalid_load");
        drive(mk(1, 32'h50, 3'd6, 4'd7, 5'b00010), 0, 0, 0, "pre_hold");
        drive(mk(1, 32'h54, 3'd1, 4'd1, 5'b11111), 0, 1, 0, "hold1");
        drive(mk(0, 32'h58, 3'd2, 4'd9, 5'b10000), 0, 1, 1, "hold2_bubble");
        drive(mk(1, 32'h5c, 3'd4, 4'd4, 5'b01001), 0, 1, 0, "hold3");
        drive(mk(1, 32'h60, 3'd2, 4'd6, 5'b00100), 0, 0, 0, "hold_release");
        drive(mk(1, 32'h64, 3'd7, 4'd8, 5'b10001), 1, 1, 1, "flush_hold_bubble");
        drive(mk(1, 32'h68, 3'd4, 4'd1, 5'b00001), 0, 0, 0, "load_pop");
        drive(mk(1, 32'h6c, 3'd5, 4'd2, 5'b11000), 1, 0, 0, "flush");

        async_reset("async_rst2");
        for (int i = 0; i < 5; i++)
            drive(mk(1, 32'h100 + 32'(i * 4), 3'd6, 4'd3, 5'b11000), 0, 0, 1,
                  $sformatf("sat_bubble%0d", i + 1));
        drive(mk(1, 32'h200, 3'd2, 4'd1, 5'b10000), 0, 0, 0, "load_after_sat");

        @(negedge clk);
        din = '0;
        @(negedge clk);
        done = 1'b1;
    end

endmodule
